// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------
// dmem_arb_pkg : shared types and widths for the data-memory arbiter
// Rev 1.0
// ---------------------------------------------------------------
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_WAIT  = 2'd1,
      ARB_FORCE = 2'd2
   } arb_state_t;

   localparam int DEF_ADDR_W = 8;
   localparam int DEF_DATA_W = 32;

   function automatic int cnt_width(input int max_val);
      return $clog2(max_val + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------
// dmem_arbiter_if : CPU, VGA and RAM signals around the arbiter
// Rev 1.0
// ---------------------------------------------------------------
interface dmem_arbiter_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   logic              cpu_en;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_stall;
   logic              vga_req;
   logic [ADDR_W-1:0] vga_addr;
   logic              vga_ack;
   logic [DATA_W-1:0] vga_rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   // Arbiter side
   modport slave (
      input  cpu_en, cpu_we, cpu_addr, cpu_wdata, vga_req, vga_addr, mem_rdata,
      output cpu_rdata, cpu_stall, vga_ack, vga_rdata, mem_addr, mem_we, mem_wdata
   );

   // Datapath / VGA / RAM side
   modport master (
      output cpu_en, cpu_we, cpu_addr, cpu_wdata, vga_req, vga_addr, mem_rdata,
      input  cpu_rdata, cpu_stall, vga_ack, vga_rdata, mem_addr, mem_we, mem_wdata
   );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter_starve_counter.sv
`default_nettype none
// ---------------------------------------------------------------
// starve_counter : saturating wait counter with clear and limit hit
// Rev 1.0
// ---------------------------------------------------------------
module starve_counter #(
   parameter int MAX = 15,
   parameter int W   = $clog2(MAX + 1)
) (
   input  wire logic         clk,
   input  wire logic         reset,
   input  wire logic         inc,
   input  wire logic         clr,
   output logic [W-1:0]      count,
   output logic              hit
);
   localparam logic [W-1:0] SAT_VAL = W'(MAX);
   localparam logic [W-1:0] HIT_VAL = W'(MAX - 1);

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         count <= '0;
      end else if (inc && (count != SAT_VAL)) begin
         count <= count + 1'b1;
      end
   end

   // Compare with >= so a saturated count still forces progress
   assign hit = (count >= HIT_VAL);

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------
// dmem_arbiter : shares one data-RAM port between CPU and VGA fetcher
// Rev 1.0
// ---------------------------------------------------------------
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int STARVE_MAX = 15
) (
   input  wire logic       clk,
   input  wire logic       reset,
   dmem_arbiter_if.slave   bus
);
   localparam int         CNT_W    = cnt_width(STARVE_MAX);
   localparam logic [1:0] ST_IDLE  = ARB_IDLE;
   localparam logic [1:0] ST_WAIT  = ARB_WAIT;
   localparam logic [1:0] ST_FORCE = ARB_FORCE;

   logic [1:0]        state;
   logic [1:0]        state_nx;
   logic              ack_q;
   logic [DATA_W-1:0] vga_rdata_q;
   logic [CNT_W-1:0]  wait_cnt;
   logic              cnt_hit;
   logic              pending;
   logic              vga_grant;
   logic [ADDR_W-1:0] grant_addr;

   // A request seen during its own ack cycle is not a new request
   assign pending   = bus.vga_req && !ack_q;
   assign vga_grant = !reset && pending && (!bus.cpu_en || (state == ST_FORCE));

   assign grant_addr    = vga_grant ? bus.vga_addr : bus.cpu_addr;
   assign bus.mem_addr  = grant_addr;
   assign bus.mem_we    = !reset && !vga_grant && bus.cpu_en && bus.cpu_we;
   assign bus.mem_wdata = bus.cpu_wdata;
   assign bus.cpu_rdata = bus.mem_rdata;
   assign bus.cpu_stall = vga_grant && bus.cpu_en;
   assign bus.vga_ack   = ack_q;
   assign bus.vga_rdata = vga_rdata_q;

   starve_counter #(
      .MAX (STARVE_MAX),
      .W   (CNT_W)
   ) u_starve (
      .clk   (clk),
      .reset (reset),
      .inc   (pending && !vga_grant),
      .clr   (vga_grant),
      .count (wait_cnt),
      .hit   (cnt_hit)
   );

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:  if (pending && bus.cpu_en) state_nx = ST_WAIT;
         ST_WAIT: begin
            if (vga_grant || !pending) state_nx = ST_IDLE;
            else if (cnt_hit)          state_nx = ST_FORCE;
         end
         ST_FORCE: state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         ack_q       <= 1'b0;
         vga_rdata_q <= '0;
      end else begin
         state <= state_nx;
         ack_q <= vga_grant;
         if (vga_grant) vga_rdata_q <= bus.mem_rdata;
      end
   end

   a_cnt_bound: assert property (@(posedge clk) disable iff (reset)
      wait_cnt <= CNT_W'(STARVE_MAX));

endmodule
`default_nettype wire
